// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the sequential fully-connected layer:
//   - state_t     : layer sequencer states
//   - ACC_GUARD   : guard bits added on top of the activation width to form
//                   the accumulator / output width
//   - accWidth()  : accumulator width derived from the activation width
//   - satMax/Min  : saturation limits of a signed accumulator of a given
//                   width, returned in a wide signed type so that callers can
//                   truncate them to whatever comparison width they need
// No ports (package).
// ---------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LATCH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int ACC_GUARD  = 3;
    localparam int SAT_CALC_W = 128;

    typedef logic signed [SAT_CALC_W-1:0] wide_t;

    function automatic int accWidth(input int dataW);
        return dataW + ACC_GUARD;
    endfunction

    function automatic wide_t satMax(input int accW);
        return (wide_t'(1) <<< (accW - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t satMin(input int accW);
        return -(wide_t'(1) <<< (accW - 1));
    endfunction

endpackage

// File: rtl/fc_mac_sat.sv
// ---------------------------------------------------------------------------
// fc_mac_sat
// One neuron lane: multiplies an activation by a weight, realigns the
// product to the activation binary point and adds it to the running
// accumulator with saturation (clamp, never wrap). Purely combinational;
// the accumulator register lives in the parent.
// Ports:
//   acc_i    in  ACC_W   current accumulator value (signed)
//   data_i   in  DATA_W  activation, FRAC_W fraction bits (signed)
//   weight_i in  W_W     weight, WFRAC fraction bits (signed)
//   sum_o    out ACC_W   saturated acc_i + (data_i*weight_i >>> WFRAC)
// ---------------------------------------------------------------------------
module fc_mac_sat
    import fc_pkg::*;
#(
    parameter int DATA_W = 35,
    parameter int FRAC_W = 28,
    parameter int W_W    = 16,
    parameter int WFRAC  = 12,
    parameter int ACC_W  = DATA_W + ACC_GUARD
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [W_W-1:0]    weight_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    // The full product carries FRAC_W+WFRAC fraction bits; dropping the
    // difference to FRAC_W puts it back on the accumulator's binary point.
    localparam int PROD_W    = DATA_W + W_W;
    localparam int SUM_W     = PROD_W + 1;
    localparam int PROD_FRAC = FRAC_W + WFRAC;
    localparam int SHIFT     = PROD_FRAC - FRAC_W;

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(satMax(ACC_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(satMin(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(satMax(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(satMin(ACC_W));

    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] term;
    logic signed [SUM_W-1:0]  sum;

    // The sum is formed one bit wider than the product so that neither the
    // shifted term nor the accumulator can overflow before the clamp looks
    // at it; the clamp then maps anything outside the accumulator range onto
    // its limits.
    always_comb begin
        product = PROD_W'(data_i) * PROD_W'(weight_i);
        term    = product >>> SHIFT;
        sum     = SUM_W'(acc_i) + SUM_W'(term);
        sum_o   = sum[ACC_W-1:0];
        if (sum > SUM_MAX) begin
            sum_o = ACC_MAX;
        end else if (sum < SUM_MIN) begin
            sum_o = ACC_MIN;
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// ---------------------------------------------------------------------------
// fc_layer_seq
// Sequential fully-connected layer. NN neurons each hold PREV weights that
// are streamed in over weight_bus while idle. A pass streams PREV
// activations in (every neuron accumulates in parallel through its own
// fc_mac_sat lane), snapshots the accumulators, then streams the NN results
// out, neuron 0 first.
// Optional feature: define FC_LAYER_RELU_EN to clip negative results to 0
// when the accumulators are snapshotted.
// Ports:
//   clk          in  1            rising-edge clock
//   rstn         in  1            synchronous active-low reset
//   start        in  1            begin a pass (only when layer_ready)
//   restart      in  1            abort to IDLE from any state
//   in_data      in  DATA_W       signed activation
//   in_valid     in  1            in_data valid
//   in_ready     out 1            activation accepted on in_valid&&in_ready
//   weight_bus   in  W_W+PART_W   {weight, part number}
//   weight_valid in  1            weight_bus valid
//   layer_ready  out 1            every neuron fully loaded
//   weight_err   out 1            sticky: weight write attempted while busy
//   out_data     out ACC_W        neuron result
//   out_valid    out 1            out_data valid
//   out_ready    in  1            sink accepts on out_valid&&out_ready
//   out_last     out 1            result of neuron NN-1
//   busy         out 1            not idle
//   done         out 1            one-cycle pulse after the last result
// ---------------------------------------------------------------------------
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int NN        = 10,
    parameter int PREV      = 10,
    parameter int DATA_W    = 35,
    parameter int FRAC_W    = 28,
    parameter int W_W       = 16,
    parameter int WFRAC     = 12,
    parameter int PART_W    = 6,
    parameter int BASE_PART = 50,
    localparam int ACC_W    = accWidth(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  restart,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W_W+PART_W-1:0] weight_bus,
    input  logic                  weight_valid,
    output logic                  layer_ready,
    output logic                  weight_err,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = (PREV > 1) ? $clog2(PREV) : 1;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PREV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NN - 1);

    state_t state_q, state_d;

    logic [KW-1:0]           k_q;
    logic [IW-1:0]           idx_q;
    logic signed [ACC_W-1:0] acc_q    [NN];
    logic signed [ACC_W-1:0] hold_q   [NN];
    logic signed [ACC_W-1:0] laneSum  [NN];
    logic signed [W_W-1:0]   weight_q [NN][PREV];
    logic [KW-1:0]           wcnt_q   [NN];
    logic [NN-1:0]           loaded_q;
    logic                    weightErr_q;
    logic                    done_q;

    logic signed [W_W-1:0] wrWeight;
    logic [31:0]           wrPart;
    logic [NN-1:0]         wrHit;
    logic                  layerReady;
    logic                  passStart;
    logic                  inAccept;
    logic                  outAccept;

    assign layerReady = &loaded_q;
    assign passStart  = (state_q == IDLE) && start && layerReady && !restart;
    assign inAccept   = (state_q == ACCUM) && in_valid;
    assign outAccept  = (state_q == DRAIN) && out_ready;

    assign wrWeight = $signed(weight_bus[W_W+PART_W-1:PART_W]);
    assign wrPart   = 32'(weight_bus[PART_W-1:0]);

    // Sequencer next state. restart is checked last so that it overrides
    // whatever the normal flow would have chosen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && layerReady) state_d = ACCUM;
            ACCUM:   if (inAccept && (k_q == K_LAST)) state_d = LATCH;
            LATCH:   state_d = DRAIN;
            DRAIN:   if (outAccept && (idx_q == I_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (restart) state_d = IDLE;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Input index k walks the weight columns during ACCUM; output index idx
    // walks the held results during DRAIN. Both return to 0 after their last
    // step so the next pass starts clean even without a restart.
    always_ff @(posedge clk) begin
        if (!rstn || restart) begin
            k_q   <= '0;
            idx_q <= '0;
        end else begin
            if (passStart)     k_q <= '0;
            else if (inAccept) k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            if (outAccept)     idx_q <= (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // done fires on the cycle after the sink takes the final result; an
    // abort on that same edge suppresses it.
    always_ff @(posedge clk) begin
        if (!rstn) done_q <= 1'b0;
        else       done_q <= !restart && outAccept && (idx_q == I_LAST);
    end

    // One saturating MAC lane per neuron, all fed the same activation and
    // each reading its own weight for the current column k.
    for (genvar n = 0; n < NN; n++) begin : gLane
        fc_mac_sat #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .W_W    (W_W),
            .WFRAC  (WFRAC),
            .ACC_W  (ACC_W)
        ) uMac (
            .acc_i    (acc_q[n]),
            .data_i   (in_data),
            .weight_i (weight_q[n][k_q]),
            .sum_o    (laneSum[n])
        );
    end

    // Accumulators start each pass from zero and take the lane result on
    // every accepted activation.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NN; n++) begin
            if (!rstn || restart || passStart) acc_q[n] <= '0;
            else if (inAccept)                 acc_q[n] <= laneSum[n];
        end
    end

    // Snapshot taken in LATCH so the drain sees a stable copy. No reset is
    // needed because out_data is forced to 0 outside DRAIN.
    always_ff @(posedge clk) begin
        if (state_q == LATCH) begin
            for (int n = 0; n < NN; n++) begin
`ifdef FC_LAYER_RELU_EN
                hold_q[n] <= acc_q[n][ACC_W-1] ? '0 : acc_q[n];
`else
                hold_q[n] <= acc_q[n];
`endif
            end
        end
    end

    // Decode which neuron (if any) a weight beat belongs to. Beats are only
    // taken while idle; part numbers outside this layer's range match
    // nothing and fall on the floor.
    always_comb begin
        wrHit = '0;
        for (int n = 0; n < NN; n++) begin
            wrHit[n] = rstn && (state_q == IDLE) && weight_valid &&
                       (wrPart == 32'(BASE_PART + n));
        end
    end

    // Weight storage is deliberately left out of reset; a reset only
    // forgets that the neurons were loaded, forcing a full reload.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NN; n++) begin
            if (wrHit[n]) weight_q[n][wcnt_q[n]] <= wrWeight;
        end
    end

    // Per-neuron write pointer wraps after PREV beats so the same neuron can
    // be reloaded later; the first wrap marks the neuron as loaded.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int n = 0; n < NN; n++) wcnt_q[n] <= '0;
            loaded_q <= '0;
        end else begin
            for (int n = 0; n < NN; n++) begin
                if (wrHit[n]) begin
                    if (wcnt_q[n] == K_LAST) begin
                        wcnt_q[n]   <= '0;
                        loaded_q[n] <= 1'b1;
                    end else begin
                        wcnt_q[n] <= wcnt_q[n] + 1'b1;
                    end
                end
            end
        end
    end

    // Any weight beat seen while a pass is running is an error that stays
    // flagged until reset, whatever its part number.
    always_ff @(posedge clk) begin
        if (!rstn)                                   weightErr_q <= 1'b0;
        else if (weight_valid && (state_q != IDLE))  weightErr_q <= 1'b1;
    end

    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == DRAIN);
    assign out_last    = out_valid && (idx_q == I_LAST);
    assign out_data    = out_valid ? hold_q[idx_q] : '0;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign layer_ready = layerReady;
    assign weight_err  = weightErr_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_seq
// Bench for fc_layer_seq with NN=2, PREV=2. A table of weight/input/result
// records is run first, then the multi-cycle corner sequences (stalled
// drain, restart, stray weight writes, reset mid-pass, partial load), then
// randomized passes checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fc_layer_seq;

    localparam int NN     = 2;
    localparam int PREV   = 2;
    localparam int DATA_W = 35;
    localparam int W_W    = 16;
    localparam int PART_W = 6;
    localparam int ACC_W  = DATA_W + 3;

`ifdef FC_LAYER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    localparam longint ACC_MAXV = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint ACC_MINV = -(64'sd1 <<< (ACC_W - 1));
    localparam longint X_MAX    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam longint X_MIN    = -(64'sd1 <<< (DATA_W - 1));

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  start;
    logic                  restart;
    logic [DATA_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [W_W+PART_W-1:0] weight_bus;
    logic                  weight_valid;
    logic                  layer_ready;
    logic                  weight_err;
    logic [ACC_W-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        longint w00, w01, w10, w11;
        longint x0, x1;
        longint e0, e1;
    } vec_t;

    vec_t vecs [4];

    fc_layer_seq #(.NN(NN), .PREV(PREV)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .restart      (restart),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .weight_bus   (weight_bus),
        .weight_valid (weight_valid),
        .layer_ready  (layer_ready),
        .weight_err   (weight_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges somewhere unforeseen.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint satAcc(input longint v);
        if (v > ACC_MAXV) return ACC_MAXV;
        if (v < ACC_MINV) return ACC_MINV;
        return v;
    endfunction

    // Reference neuron: fixed-point dot product using plain integer maths,
    // each term floored to the activation scale, running sum clamped.
    function automatic longint refNeuron(input longint wa, input longint wb,
                                         input longint xa, input longint xb);
        longint acc;
        acc = 0;
        acc = satAcc(acc + ((xa * wa) >>> 12));
        acc = satAcc(acc + ((xb * wb) >>> 12));
        if (RELU && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic writeWeight(input int part, input longint w);
        logic [W_W-1:0]    wb;
        logic [PART_W-1:0] pb;
        wb = W_W'(w);
        pb = PART_W'(part);
        weight_bus   = {wb, pb};
        weight_valid = 1'b1;
        @(negedge clk);
        weight_valid = 1'b0;
    endtask

    task automatic loadNeurons(input vec_t v);
        writeWeight(50, v.w00);
        writeWeight(50, v.w01);
        writeWeight(51, v.w10);
        writeWeight(51, v.w11);
    endtask

    // One full pass: start, feed both activations (optionally with bubbles),
    // check the two-cycle latency, optionally hold the sink off, then drain
    // and check order, out_last and the done pulse.
    task automatic runPass(input string tag, input longint x0, input longint x1,
                           input longint e0, input longint e1, input int stallCycles,
                           input bit gaps, input bit strayWrite);
        longint xs [2];
        longint es [2];
        int     k;
        int     guard;
        bit     took;
        xs[0] = x0; xs[1] = x1;
        es[0] = e0; es[1] = e1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " busy after start"}, longint'(busy), 1);
        k = 0;
        guard = 0;
        while (k < PREV && guard < 40) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = xs[k][DATA_W-1:0];
            if (strayWrite && guard == 0) begin
                weight_bus   = {16'd999, 6'd50};
                weight_valid = 1'b1;
            end
            took = in_valid && in_ready;
            @(negedge clk);
            weight_valid = 1'b0;
            if (took) k++;
            guard++;
        end
        in_valid = 1'b0;
        checkOutput({tag, " inputs accepted"}, longint'(k), PREV);
        checkOutput({tag, " in_ready low after last input"}, longint'(in_ready), 0);
        checkOutput({tag, " no out_valid one cycle after last input"}, longint'(out_valid), 0);
        @(negedge clk);
        checkOutput({tag, " out_valid two cycles after last input"}, longint'(out_valid), 1);
        out_ready = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
            checkOutput({tag, " data held while stalled"}, longint'($signed(out_data)), es[0]);
            @(negedge clk);
        end
        for (int i = 0; i < NN; i++) begin
            guard = 0;
            took  = 1'b0;
            while (!took && guard < 20) begin
                out_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                took = out_valid && out_ready;
                checkOutput($sformatf("%s out_data[%0d]", tag, i), longint'($signed(out_data)), es[i]);
                if (took) checkOutput($sformatf("%s out_last[%0d]", tag, i), longint'(out_last), longint'(i == NN - 1));
                @(negedge clk);
                guard++;
            end
            checkOutput($sformatf("%s output %0d accepted", tag, i), longint'(took), 1);
        end
        out_ready = 1'b0;
        checkOutput({tag, " done pulse"}, longint'(done), 1);
        checkOutput({tag, " idle after drain"}, longint'(busy), 0);
        @(negedge clk);
        checkOutput({tag, " done lasts one cycle"}, longint'(done), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        loadNeurons(v);
        checkOutput({tag, " layer_ready after load"}, longint'(layer_ready), 1);
        runPass(tag, v.x0, v.x1, v.e0, v.e1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t rv;
        rstn         = 1'b0;
        start        = 1'b0;
        restart      = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        weight_bus   = '0;
        weight_valid = 1'b0;
        out_ready    = 1'b0;

        // 1.0 activation = 2^28, 1.0 weight = 4096
        vecs[0] = '{4096, 8192, -4096, 0, 2**28, 2**27,
                    2**29, (RELU ? 0 : -(2**28))};
        vecs[1] = '{32767, 32767, -32768, -32768, X_MAX, X_MAX,
                    ACC_MAXV, (RELU ? 0 : ACC_MINV)};
        vecs[2] = '{2048, -1024, 4096, 4096, -(2**28), 3 * (2**26),
                    (RELU ? 0 : -11 * (2**24)), (RELU ? 0 : -(2**26))};
        vecs[3] = '{1, 1, 3, -1, -1, 5,
                    (RELU ? 0 : -1), (RELU ? 0 : -2)};

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", longint'(in_ready), 0);
        checkOutput("reset out_valid", longint'(out_valid), 0);
        checkOutput("reset out_last", longint'(out_last), 0);
        checkOutput("reset busy", longint'(busy), 0);
        checkOutput("reset done", longint'(done), 0);
        checkOutput("reset layer_ready", longint'(layer_ready), 0);
        checkOutput("reset weight_err", longint'(weight_err), 0);
        checkOutput("reset out_data", longint'($signed(out_data)), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Sink holds off for five cycles at the start of the drain.
        loadNeurons(vecs[0]);
        runPass("stall", vecs[0].x0, vecs[0].x1, vecs[0].e0, vecs[0].e1, 5, 1'b0, 1'b0);

        // Abort after one activation, then rerun on the retained weights.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = vecs[0].x0[DATA_W-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("restart still accumulating", longint'(busy), 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkOutput("restart busy", longint'(busy), 0);
        checkOutput("restart in_ready", longint'(in_ready), 0);
        checkOutput("restart out_valid", longint'(out_valid), 0);
        checkOutput("restart done", longint'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("restart no late done", longint'(done), 0);
        end
        runPass("after restart", vecs[0].x0, vecs[0].x1, vecs[0].e0, vecs[0].e1, 0, 1'b0, 1'b0);

        // Foreign part numbers while idle are ignored without an error.
        writeWeight(63, 12345);
        writeWeight(52, 23456);
        checkOutput("foreign part weight_err", longint'(weight_err), 0);
        runPass("foreign part", vecs[0].x0, vecs[0].x1, vecs[0].e0, vecs[0].e1, 0, 1'b0, 1'b0);

        // A weight beat during ACCUM is refused and flagged.
        runPass("stray write", vecs[0].x0, vecs[0].x1, vecs[0].e0, vecs[0].e1, 0, 1'b0, 1'b1);
        checkOutput("stray write weight_err", longint'(weight_err), 1);
        writeWeight(63, 1);
        checkOutput("weight_err sticky", longint'(weight_err), 1);
        applyStimulus(vecs[2], "reload after stray");

        // Reset in the middle of a pass, then an incomplete reload.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = vecs[1].x0[DATA_W-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checkOutput("mid-pass reset busy", longint'(busy), 0);
        checkOutput("mid-pass reset layer_ready", longint'(layer_ready), 0);
        checkOutput("mid-pass reset weight_err", longint'(weight_err), 0);
        checkOutput("mid-pass reset out_valid", longint'(out_valid), 0);
        writeWeight(50, vecs[1].w00);
        writeWeight(50, vecs[1].w01);
        writeWeight(51, vecs[1].w10);
        checkOutput("half loaded layer_ready", longint'(layer_ready), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start ignored when not loaded", longint'(busy), 0);
        writeWeight(51, vecs[1].w11);
        checkOutput("load completed layer_ready", longint'(layer_ready), 1);
        runPass("after completing load", vecs[1].x0, vecs[1].x1, vecs[1].e0, vecs[1].e1, 0, 1'b0, 1'b0);

        // Randomized passes with bubbles and back-pressure.
        for (int r = 0; r < 16; r++) begin
            rv.w00 = longint'($signed(16'($urandom())));
            rv.w01 = longint'($signed(16'($urandom())));
            rv.w10 = longint'($signed(16'($urandom())));
            rv.w11 = longint'($signed(16'($urandom())));
            rv.x0  = longint'($signed(35'({$urandom(), $urandom()})));
            rv.x1  = longint'($signed(35'({$urandom(), $urandom()})));
            if ($urandom_range(0, 3) == 0) rv.x0 = ($urandom_range(0, 1) == 1) ? X_MAX : X_MIN;
            if ($urandom_range(0, 3) == 0) rv.x1 = ($urandom_range(0, 1) == 1) ? X_MAX : X_MIN;
            rv.e0 = refNeuron(rv.w00, rv.w01, rv.x0, rv.x1);
            rv.e1 = refNeuron(rv.w10, rv.w11, rv.x0, rv.x1);
            loadNeurons(rv);
            runPass($sformatf("rand%0d", r), rv.x0, rv.x1, rv.e0, rv.e1,
                    int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
